// File: rtl/serial_cmp.sv
// Bit-serial unsigned magnitude comparator: x and y arrive MSB first, one bit per
// accepted beat; EQ/LT are reported with a one-cycle done pulse after WIDTH beats.
module serial_cmp #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_valid,
    input  logic xb,
    input  logic yb,
    output logic busy,
    output logic done,
    output logic EQ,
    output logic LT
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_eq, r_lt;
    logic          r_busy, r_done, r_EQ, r_LT;
    logic          w_take, w_last, w_eq_nxt, w_lt_nxt, w_init;

    // Decision is made at the first differing bit (MSB first) and then frozen.
    always_comb begin
        w_eq_nxt = r_eq;
        w_lt_nxt = r_lt;
        if (r_eq && (xb != yb)) begin
            w_eq_nxt = 1'b0;
            w_lt_nxt = ~xb & yb;
        end
    end

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_last = 1'b0;
        w_init = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                    w_init = 1'b1;
                end
            end
            S_RUN: begin
                w_take = bit_valid;
                w_last = bit_valid && (r_cnt == CW'(WIDTH - 1));
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_init = start;
                w_next = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_eq    <= 1'b1;
            r_lt    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_EQ    <= 1'b0;
            r_LT    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
            if (w_init) begin
                r_cnt <= '0;
                r_eq  <= 1'b1;
                r_lt  <= 1'b0;
            end else if (w_take) begin
                r_cnt <= r_cnt + CW'(1);
                r_eq  <= w_eq_nxt;
                r_lt  <= w_lt_nxt;
            end
            // Results include the last bit's contribution and hold until the next done.
            if (w_last) begin
                r_EQ <= w_eq_nxt;
                r_LT <= w_lt_nxt;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign EQ   = r_EQ;
    assign LT   = r_LT;
endmodule
